// File: rtl/i2s_tx.sv
// I2S transmitter: one stereo pair per frame, MSB first with the standard one-bit delay after LRCLK.
// Define I2S_TX_UNDERRUN_CNT_EN to add a saturating 16-bit underrun counter output.
module i2s_tx #(
  parameter int CLK_DIV      = 2,
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] s_left,
  input  logic [SAMPLE_WIDTH-1:0] s_right,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    bclk,
  output logic                    lrclk,
  output logic                    sdata,
  output logic                    underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]             underrun_cnt
`endif
);

  localparam int FW     = 2 * SAMPLE_WIDTH;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(FW);

  logic [DIV_W-1:0]        div_q, div_d;
  logic                    bclk_q, bclk_d;
  logic [SLOT_W-1:0]       slot_q, slot_d, slot_nxt;
  logic                    lrclk_q, lrclk_d;
  logic                    sdata_q, sdata_d;
  logic [FW-1:0]           frame_q, frame_d;
  logic                    rbit_q, rbit_d;
  logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic                    full_q, full_d;
  logic                    ready_q, ready_d;
  logic                    und_q, und_d;
  logic                    div_wrap, fall, cap, accept;

  assign div_wrap = (div_q == DIV_W'(CLK_DIV - 1));
  assign fall     = div_wrap & bclk_q;
  assign cap      = fall & (slot_q == SLOT_W'(FW - 1));
  assign accept   = s_valid & ready_q;
  assign slot_nxt = (slot_q == SLOT_W'(FW - 1)) ? '0 : slot_q + 1'b1;

  always_comb begin
    div_d    = div_wrap ? '0 : div_q + 1'b1;
    bclk_d   = div_wrap ? ~bclk_q : bclk_q;
    slot_d   = slot_q;
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    frame_d  = frame_q;
    rbit_d   = rbit_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    full_d   = full_q;
    und_d    = 1'b0;
    if (accept) begin
      hold_l_d = s_left;
      hold_r_d = s_right;
      full_d   = 1'b1;
    end
    if (fall) begin
      slot_d  = slot_nxt;
      lrclk_d = (slot_nxt >= SLOT_W'(SAMPLE_WIDTH));
      if (cap) begin
        // Slot 0 still belongs to the previous frame: emit its R[0].
        sdata_d = rbit_q;
        if (full_q) begin
          frame_d = {hold_l_q, hold_r_q};
          full_d  = 1'b0;
        end else begin
          // Starved: zero frame; a coincident accept stays held for the next frame.
          frame_d = '0;
          und_d   = 1'b1;
        end
        rbit_d = frame_d[0];
      end else begin
        sdata_d = frame_q[FW-1];
        frame_d = {frame_q[FW-2:0], 1'b0};
      end
    end
    ready_d = ~full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      bclk_q   <= 1'b0;
      slot_q   <= SLOT_W'(FW - 1);
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      frame_q  <= '0;
      rbit_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      full_q   <= 1'b0;
      ready_q  <= 1'b1;
      und_q    <= 1'b0;
    end else begin
      div_q    <= div_d;
      bclk_q   <= bclk_d;
      slot_q   <= slot_d;
      lrclk_q  <= lrclk_d;
      sdata_q  <= sdata_d;
      frame_q  <= frame_d;
      rbit_q   <= rbit_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      full_q   <= full_d;
      ready_q  <= ready_d;
      und_q    <= und_d;
    end
  end

  assign s_ready  = ready_q;
  assign bclk     = bclk_q;
  assign lrclk    = lrclk_q;
  assign sdata    = sdata_q;
  assign underrun = und_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          ucnt_q <= '0;
    else if (und_d && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx (CLK_DIV=2, SAMPLE_WIDTH=16): stimulus queues expected frames,
// an I2S decoder process reassembles frames from the pins and compares.
module tb_i2s_tx;
  localparam int W  = 16;
  localparam int FW = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] s_left = '0, s_right = '0;
  logic         s_valid = 1'b0;
  logic         s_ready, bclk, lrclk, sdata, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]  underrun_cnt;
`endif

  i2s_tx #(.CLK_DIV(2), .SAMPLE_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .s_left(s_left), .s_right(s_right), .s_valid(s_valid),
    .s_ready(s_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, spurious = 0, pcnt;
  bit          exp_und_q[$];
  logic [FW-1:0] exp_word_q[$];

  always @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= 0;
    else        pcnt <= pcnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, pcnt);
    end
  endtask

  // Monitor: decode I2S from the pins and pop the scoreboard.
  initial begin : mon
    int ms = FW - 1;
    bit bprev = 0, cur_v = 0, have_fall = 0, have_cap = 0, prev_acc = 0;
    int last_fall = 0, last_cap = 0;
    logic [FW-1:0] word = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        ms = FW - 1; bprev = 0; cur_v = 0; have_fall = 0; have_cap = 0; prev_acc = 0;
      end else begin
        if (prev_acc) check("ready_low_after_accept", s_ready, 0);
        prev_acc = s_valid && s_ready;
        if (bprev && !bclk) begin
          if (have_fall) check("bclk_period", pcnt - last_fall, 4);
          else           check("first_fall_cycle", pcnt, 4);
          have_fall = 1; last_fall = pcnt;
          ms = (ms + 1) % FW;
          check("lrclk_slot", lrclk, (ms >= W));
          if (ms == 0) begin
            if (cur_v) begin
              word[0] = sdata;
              if (exp_word_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL frame_word: got %0h with no frame expected", word);
              end else check("frame_word", word, exp_word_q.pop_front());
            end
            if (have_cap) check("frame_period", pcnt - last_cap, 128);
            have_cap = 1; last_cap = pcnt; cur_v = 1; word = '0;
            if (exp_und_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL capture_unexpected: got capture at cycle %0d, required none", pcnt);
            end else check("underrun_at_capture", underrun, exp_und_q.pop_front());
            if (!underrun) check("ready_after_capture", s_ready, 1);
          end else begin
            word[FW-ms] = sdata;
            if (underrun) spurious++;
          end
        end else if (underrun) spurious++;
        bprev = bclk;
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (pcnt < n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input bit hold);
    int n = 0;
    s_left = l; s_right = r; s_valid = 1'b1;
    while (!s_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout: got no s_ready in %0d cycles, required within 300", n);
    end
    @(negedge clk);
    if (!hold) s_valid = 1'b0;
  endtask

  // Called at a negedge; asserts reset immediately and releases on a later negedge.
  task automatic apply_reset();
    check("und_q_drained", exp_und_q.size(), 0);
    check("word_q_drained", exp_word_q.size(), 0);
    exp_und_q.delete(); exp_word_q.delete();
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    check("rst_bclk", bclk, 0);
    check("rst_lrclk", lrclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_underrun", underrun, 0);
    check("rst_s_ready", s_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    apply_reset();

    // Idle: every frame is a zero frame with an underrun pulse.
    repeat (4) exp_und_q.push_back(1'b1);
    repeat (3) exp_word_q.push_back('0);
    wait_cyc(300);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("underrun_cnt_3", underrun_cnt, 3);
`endif
    wait_cyc(400);
    apply_reset();

    // Pair accepted before the first capture; later input changes must not leak.
    exp_und_q.push_back(1'b0); exp_und_q.push_back(1'b1); exp_und_q.push_back(1'b1);
    exp_word_q.push_back({16'hA5C3, 16'h0F01}); exp_word_q.push_back('0);
    send(16'hA5C3, 16'h0F01, 1'b0);
    s_left = 16'hDEAD; s_right = 16'hBEEF;
    wait_cyc(300);
    apply_reset();

    // Accept coinciding with the first capture, then reset at slot 20.
    exp_und_q.push_back(1'b1); exp_und_q.push_back(1'b0); exp_und_q.push_back(1'b0);
    exp_word_q.push_back('0); exp_word_q.push_back({16'h1234, 16'h8001});
    repeat (3) @(negedge clk);
    send(16'h1234, 16'h8001, 1'b0);
    wait_cyc(140);
    send(16'hFFFF, 16'hFFFF, 1'b0);
    wait_cyc(342);
    check("slot20_bclk", bclk, 1);
    check("slot20_lrclk", lrclk, 1);
    check("slot20_sdata", sdata, 1);
    apply_reset();

    // Streaming with s_valid held high: one accept per frame, nothing lost or repeated.
    for (int i = 0; i < 5; i++) begin
      exp_und_q.push_back(1'b0);
      exp_word_q.push_back({16'h0100 + 16'(i), 16'h8001 + 16'(i)});
    end
    exp_und_q.push_back(1'b1);
    for (int i = 0; i < 5; i++) send(16'h0100 + 16'(i), 16'h8001 + 16'(i), (i < 4));
    wait_cyc(650);
    apply_reset();

`ifdef I2S_TX_UNDERRUN_CNT_EN
    exp_und_q.push_back(1'b1); exp_und_q.push_back(1'b1);
    exp_word_q.push_back('0);
    @(negedge clk);
    force dut.ucnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.ucnt_q;
    wait_cyc(140);
    check("underrun_cnt_sat", underrun_cnt, 16'hFFFF);
    apply_reset();
`endif

    check("no_spurious_underrun", spurious, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2, meaning clk cycles per BCLK half-period; legal range 1..255.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 16, meaning bits per channel; legal range 8..32.
REQ-003 SHALL have port clk, input, 1, meaning the single clock (PLL divided output); all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port s_left, input, SAMPLE_WIDTH, meaning the left sample, two's complement.
REQ-006 SHALL have port s_right, input, SAMPLE_WIDTH, meaning the right sample, two's complement.
REQ-007 SHALL have port s_valid, input, 1, meaning the stereo pair is offered.
REQ-008 SHALL have port s_ready, output, 1, meaning the holding register is empty.
REQ-009 SHALL have port bclk, output, 1, meaning the I2S bit clock.
REQ-010 SHALL have port lrclk, output, 1, meaning word select (0 = left, 1 = right).
REQ-011 SHALL have port sdata, output, 1, meaning I2S serial data.
REQ-012 SHALL have port underrun, output, 1, meaning a one-cycle pulse for each frame sent without data.

Function
REQ-013 SHALL use a divider counter 0..CLK_DIV-1; on wrap, bclk toggles, so the BCLK period is 2*CLK_DIV clk cycles.
REQ-014 SHALL use a slot counter 0..2*SAMPLE_WIDTH-1 that advances on each bclk falling edge (the clk where bclk goes 1->0) and wraps to 0.
REQ-015 SHALL change lrclk, sdata, slot counter and frame capture only on bclk-falling clk cycles; all outputs are registered.
REQ-016 SHALL drive lrclk 0 for slots 0..SAMPLE_WIDTH-1 and 1 for slots SAMPLE_WIDTH..2*SAMPLE_WIDTH-1.
REQ-017 SHALL drive sdata as frame word {L,R}, MSB first, delayed by one slot: slot k (1..2W-1) carries frame bit 2W-k; slot 0 carries R[0] of the previous frame (standard I2S one-bit delay).
REQ-018 SHALL capture the holding register into the frame shifter on the bclk-falling cycle entering slot 0, while separately retaining the prior R[0] for slot 0.
REQ-019 SHALL accept s_left/s_right into the holding register when s_valid && s_ready; s_ready is 0 from the next cycle.
REQ-020 SHALL reassert s_ready on the cycle after a capture empties the holding register.
REQ-021 SHALL treat capture with an empty holding register as underrun: a zero frame is sent and underrun pulses high for exactly that capture cycle.
REQ-022 SHALL, when an accept coincides with an underrun capture, send the zero frame and keep the accepted pair for the next frame.
REQ-023 SHALL keep input values stable in the holding register; later changes on s_left/s_right have no effect until the next accept.

Reset
REQ-024 SHALL, while rst_n=0, set bclk=0, lrclk=0, sdata=0, underrun=0, s_ready=1, divider=0, slot counter=2*SAMPLE_WIDTH-1, and holding, frame and retained bits to 0.
REQ-025 SHALL put the first bclk falling edge, entering slot 0, at clk cycle 2*CLK_DIV after rst_n deassertion.
REQ-026 SHALL, on reset asserted mid-frame, abort immediately with no partial-frame completion.

Configuration
REQ-027 SHALL, when I2S_TX_UNDERRUN_CNT_EN is defined, add output underrun_cnt[15:0], which increments on each underrun pulse, saturates at 16'hFFFF and resets to 0.
REQ-028 SHALL, without I2S_TX_UNDERRUN_CNT_EN, have no underrun_cnt port or counter; all other behaviour is identical.

Verification (CLK_DIV=2, SAMPLE_WIDTH=16)
REQ-029 SHALL verify: reset release, no s_valid -> bclk period 4 clk; lrclk period 128 clk; first falling edge at cycle 4; sdata stays 0; underrun pulses every 128 clk.
REQ-030 SHALL verify: pair L=16'hA5C3, R=16'h0F01 accepted before the first capture -> slots 1..16 give A5C3 MSB first; slots 17..31 give 0F01[15:1]; the next slot 0 gives 1; no underrun.
REQ-031 SHALL verify: s_valid held high with incrementing data -> exactly one accept per 128 clk; s_ready low from the cycle after accept until the cycle after capture; no underrun; no sample lost or repeated.
REQ-032 SHALL verify: first accept on the same cycle as the slot-0 capture -> a zero frame plus an underrun pulse, then the accepted pair in the following frame.
REQ-033 SHALL verify: rst_n pulled low at slot 20 -> all outputs at reset values within the same cycle (asynchronous); timing restarts per REQ-025.
REQ-034 SHALL verify, with I2S_TX_UNDERRUN_CNT_EN defined: 3 starved frames -> underrun_cnt=3; forced counter at 16'hFFFE plus 2 underruns -> 16'hFFFF.
